// File: rtl/sram_pkg.sv
// sram_pkg: shared types, widths and strobe decoding for the SRAM responder.
//   SRAM_ADDR_W / SRAM_DATA_W : processor-side address and data widths.
//   state_t                   : responder FSM states.
//   op_t / classify()         : decode of the sampled active-low strobes.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR
  } state_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } op_t;

  // Sampled copy of the processor strobes (all active-low).
  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobes_t;

  // A write wins over OE, so WE low with CE low is always a write.
  function automatic op_t classify(input logic ce, input logic oe, input logic we);
    if (!ce && !we) return OP_WRITE;
    if (!ce && !oe) return OP_READ;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: processor strobe/address bus plus the program loader
// valid/ready port. The bidirectional Data bus stays a plain inout port.
//   CE/UB/LB/OE/WE : active-low strobes from the processor.
//   ADDR           : processor word address.
//   Ld_Valid/Ld_Addr/Ld_Data : loader word offer.
//   Ld_Ready       : responder can accept a loader word this cycle.
interface sram_responder_if #(
  parameter int ADDR_BITS = 10
);
  import sram_pkg::*;

  logic                   CE;
  logic                   UB;
  logic                   LB;
  logic                   OE;
  logic                   WE;
  logic [SRAM_ADDR_W-1:0] ADDR;
  logic                   Ld_Valid;
  logic [ADDR_BITS-1:0]   Ld_Addr;
  logic [SRAM_DATA_W-1:0] Ld_Data;
  logic                   Ld_Ready;

  modport master (
    output CE, UB, LB, OE, WE, ADDR, Ld_Valid, Ld_Addr, Ld_Data,
    input  Ld_Ready
  );

  modport slave (
    input  CE, UB, LB, OE, WE, ADDR, Ld_Valid, Ld_Addr, Ld_Data,
    output Ld_Ready
  );

endinterface

// File: rtl/sram_array.sv
// sram_array: single-port block RAM, 16-bit words, two byte-lane write
// enables and a registered read. Storage has no reset so it maps onto M9K.
//   clk   : clock
//   we    : byte write enables, we[1] -> wdata[15:8], we[0] -> wdata[7:0]
//   addr  : word address (shared by read and write)
//   wdata : write word
//   rdata : word at addr, registered (old data on a same-edge write)
module sram_array
  import sram_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic [1:0]             we,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata
);

  logic [1:0][7:0]        mem [2**ADDR_BITS];
  logic [SRAM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][1] <= wdata[15:8];
    if (we[0]) mem[addr][0] <= wdata[7:0];
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the board's asynchronous 16-bit SRAM.
// Samples the processor strobes every edge, serves byte-lane reads with a
// fixed READ_LATENCY (legal 2..4) and byte-lane writes, and accepts loader
// words while the processor leaves the chip deselected.
//   Clk   : system clock
//   Reset : asynchronous, active-low
//   bus   : strobes, ADDR and loader handshake (slave side)
//   Data  : bidirectional data bus, Z unless a read is being presented
//   Err   : sticky flag, set by any access above the implemented depth
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  sram_responder_if.slave        bus,
  inout  wire  [SRAM_DATA_W-1:0] Data,
  output logic                   Err
);

  // Two bits cover a reload value of READ_LATENCY-1 up to 3.
  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  strobes_t               smp_d, smp_q;
  logic [SRAM_ADDR_W-1:0] addr_d, addr_q;
  logic [SRAM_DATA_W-1:0] wdat_d, wdat_q;
  logic [SRAM_ADDR_W-1:0] rd_addr_d, rd_addr_q;
  state_t                 state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   err_d, err_q;
  logic                   live_d, live_q;

  op_t                    op;
  logic                   oor;
  logic                   rd_oor;
  logic                   addr_chg;
  logic                   proc_wr;
  logic                   ld_ready;
  logic                   ld_xfer;
  logic [1:0]             mem_we;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [SRAM_DATA_W-1:0] mem_wdata;
  logic [SRAM_DATA_W-1:0] mem_rdata;
  logic [SRAM_DATA_W-1:0] rd_word;
  logic                   drv_base;
  logic                   drv_hi;
  logic                   drv_lo;

  // Input sample stage
  always_comb begin
    smp_d  = '{ce: bus.CE, ub: bus.UB, lb: bus.LB, oe: bus.OE, we: bus.WE};
    addr_d = bus.ADDR;
    wdat_d = Data;
    live_d = 1'b1;
  end

  // FSM, latency counter and error flag
  always_comb begin
    op       = classify(smp_q.ce, smp_q.oe, smp_q.we);
    oor      = |addr_q[SRAM_ADDR_W-1:ADDR_BITS];
    rd_oor   = |rd_addr_q[SRAM_ADDR_W-1:ADDR_BITS];
    addr_chg = (addr_q != rd_addr_q);

    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q | ((op != OP_IDLE) & oor);

    case (state_q)
      IDLE, WR: begin
        if (op == OP_WRITE) begin
          state_d = WR;
        end else if (op == OP_READ) begin
          state_d   = RD_WAIT;
          cnt_d     = CNT_LOAD;
          rd_addr_d = addr_q;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT, RD_DRIVE: begin
        if (op == OP_WRITE) begin
          state_d = WR;
        end else if (op == OP_READ) begin
          if (addr_chg) begin
            state_d   = RD_WAIT;
            cnt_d     = CNT_LOAD;
            rd_addr_d = addr_q;
          end else if (state_q == RD_WAIT) begin
            // Drive from the edge at which the count reaches zero.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RD_DRIVE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port arbitration. The loader is only ready while the sampled CE is
  // high, i.e. while no processor access can be in the sample register.
  always_comb begin
    proc_wr  = (op == OP_WRITE) & ~oor;
    ld_ready = live_q & (state_q == IDLE) & smp_q.ce;
    ld_xfer  = bus.Ld_Valid & ld_ready;

    mem_we    = 2'b00;
    mem_addr  = addr_q[ADDR_BITS-1:0];
    mem_wdata = wdat_q;
    if (proc_wr) begin
      mem_we = {~smp_q.ub, ~smp_q.lb};
    end else if (ld_xfer) begin
      mem_we    = 2'b11;
      mem_addr  = bus.Ld_Addr;
      mem_wdata = bus.Ld_Data;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      smp_q   <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      smp_q   <= smp_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      live_q  <= live_d;
    end
  end

  always_ff @(posedge Clk) begin
    addr_q    <= addr_d;
    wdat_q    <= wdat_d;
    rd_addr_q <= rd_addr_d;
  end

  sram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (Clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // Output drive. The sampled-address match keeps the previous word off the
  // bus during the cycle in which a new address has been sampled but the FSM
  // has not yet left RD_DRIVE; the raw-pin terms release the bus in the same
  // cycle the processor deasserts.
  always_comb begin
    rd_word  = rd_oor ? '0 : mem_rdata;
    drv_base = (state_q == RD_DRIVE) & ~addr_chg & ~bus.CE & ~bus.OE & bus.WE;
    drv_hi   = drv_base & ~bus.UB;
    drv_lo   = drv_base & ~bus.LB;
  end

  assign Data[15:8]   = drv_hi ? rd_word[15:8] : 8'hzz;
  assign Data[7:0]    = drv_lo ? rd_word[7:0]  : 8'hzz;
  assign bus.Ld_Ready = ld_ready;
  assign Err          = err_q;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
  import sram_pkg::*;

  localparam int ADDR_BITS    = 10;
  localparam int READ_LATENCY = 2;

  typedef struct {
    logic [15:0] val;
    string       tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err;
  logic        tb_drv_en = 1'b0;
  logic [15:0] tb_drv_val = 16'h0000;
  wire  [15:0] Data;

  int          n_checks = 0;
  int          n_pass = 0;
  int          xfers = 0;
  logic [15:0] model [1024];
  logic [15:0] ld_vals [4];
  sb_t         sb_q [$];

  always #10 clk = ~clk;

  sram_responder_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  assign Data = tb_drv_en ? tb_drv_val : 16'hzzzz;

  sram_responder #(
    .ADDR_BITS   (ADDR_BITS),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus),
    .Data (Data),
    .Err  (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1; bus.UB = 1'b1; bus.LB = 1'b1;
    tb_drv_en = 1'b0;
  endtask

  task automatic start_read(input logic [19:0] a, input string tag);
    sb_t e;
    tb_drv_en = 1'b0;
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.ADDR = a;
    e.val = ((a >> ADDR_BITS) != 0) ? 16'h0000 : model[a[ADDR_BITS-1:0]];
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic start_write(input logic [19:0] a, input logic [15:0] d,
                             input logic ub, input logic lb, input logic oe);
    bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = oe; bus.UB = ub; bus.LB = lb;
    bus.ADDR = a;
    tb_drv_en = 1'b1; tb_drv_val = d;
    if ((a >> ADDR_BITS) == 0) begin
      if (!ub) model[a[ADDR_BITS-1:0]][15:8] = d[15:8];
      if (!lb) model[a[ADDR_BITS-1:0]][7:0]  = d[7:0];
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check(e.tag, 32'(Data), 32'(e.val));
  endtask

  initial begin
    ld_vals[0] = 16'h1234; ld_vals[1] = 16'h0006;
    ld_vals[2] = 16'h3333; ld_vals[3] = 16'h5555;
    idle_bus();
    bus.ADDR = '0; bus.Ld_Valid = 1'b0; bus.Ld_Addr = '0; bus.Ld_Data = '0;

    // Reset state
    step(); step();
    check("rst_data_z", 32'(Data === 16'hzzzz), 32'd1);
    check("rst_ld_ready", 32'(bus.Ld_Ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();
    check("ld_ready_after_rst", 32'(bus.Ld_Ready), 32'd1);

    // Loader preload of 0x000..0x003
    bus.Ld_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Ld_Addr = ADDR_BITS'(i);
      bus.Ld_Data = ld_vals[i];
      check($sformatf("ld_ready_%0d", i), 32'(bus.Ld_Ready), 32'd1);
      if (bus.Ld_Ready) begin
        model[i] = ld_vals[i];
        xfers++;
      end
      step();
    end
    bus.Ld_Valid = 1'b0;
    check("ld_xfers", 32'(xfers), 32'd4);
    check("ld_err", 32'(err), 32'd0);

    // Read 0x001: Z through edge k+1, valid after k+2 and held
    start_read(20'h00001, "rd_001");
    step();
    check("rd_001_z_k", 32'(Data === 16'hzzzz), 32'd1);
    step();
    check("rd_001_z_k1", 32'(Data === 16'hzzzz), 32'd1);
    step();
    sb_check();
    step();
    check("rd_001_hold", 32'(Data), 32'(model[1]));
    idle_bus();
    #1;
    check("rd_001_release", 32'(Data === 16'hzzzz), 32'd1);
    step();

    // Upper-byte write to 0x002, then read sampled on the commit edge
    start_write(20'h00002, 16'hAB00, 1'b0, 1'b1, 1'b1);
    step();
    start_read(20'h00002, "rd_002_byte");
    step(); step(); step();
    sb_check();
    check("rd_002_model", 32'(model[2]), 32'h0000AB33);
    bus.UB = 1'b1;
    #1;
    check("rd_002_ub_off", 32'(Data === 16'hzz33), 32'd1);
    idle_bus();
    step(); step();

    // Back-to-back full-word writes with OE also low (write wins)
    start_write(20'h00010, 16'hC0DE, 1'b0, 1'b0, 1'b0);
    step();
    start_write(20'h00011, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    step();
    start_read(20'h00010, "rd_010_b2b");
    step(); step(); step();
    sb_check();
    start_read(20'h00011, "rd_011_b2b");
    step(); step(); step();
    sb_check();
    idle_bus();
    step(); step();

    // Address change mid-read: two Z cycles, then the new word
    start_read(20'h00000, "rd_000");
    step(); step(); step();
    sb_check();
    start_read(20'h00003, "rd_003_after_chg");
    step();
    check("chg_z1", 32'(Data === 16'hzzzz), 32'd1);
    step();
    check("chg_z2", 32'(Data === 16'hzzzz), 32'd1);
    step();
    sb_check();
    bus.OE = 1'b1;
    #1;
    check("oe_release", 32'(Data === 16'hzzzz), 32'd1);
    idle_bus();
    step(); step();

    // Out-of-range read and write
    check("err_pre_oor", 32'(err), 32'd0);
    start_read(20'h00400, "rd_oor_zero");
    step(); step();
    check("err_set", 32'(err), 32'd1);
    step();
    sb_check();
    check("rd_oor_driven", 32'(Data === 16'hzzzz), 32'd0);
    idle_bus();
    step(); step();
    check("err_sticky", 32'(err), 32'd1);
    start_write(20'h00400, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    step();
    idle_bus();
    step(); step();
    start_read(20'h00000, "rd_000_after_oor_wr");
    step(); step(); step();
    sb_check();

    // Reset while presenting a read
    idle_bus();
    step(); step();
    start_read(20'h00003, "rd_003_pre_rst");
    step(); step(); step();
    sb_check();
    rst_n = 1'b0;
    #1;
    check("rst_mid_data_z", 32'(Data === 16'hzzzz), 32'd1);
    check("rst_mid_err", 32'(err), 32'd0);
    idle_bus();
    step();
    check("rst_mid_ld_ready", 32'(bus.Ld_Ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("ld_ready_after_rst2", 32'(bus.Ld_Ready), 32'd1);
    start_read(20'h00003, "rd_003_retained");
    step(); step(); step();
    sb_check();
    idle_bus();
    step();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
